// File: rtl/multi_sync_filter.sv
// multi_sync_filter: per-channel flop-chain synchronizer followed by a stability
// filter that accepts a new level only after FILTER_CNT consecutive steady cycles.
// Optional rise/fall/change strobes are built when MULTI_SYNC_FILTER_EDGE_EN is
// defined; otherwise those outputs are tied low and no pulse flops exist.

module multi_sync_filter #(
    parameter int unsigned        CH_NUM      = 8,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter int unsigned        FIRST_EDGE  = 1,
    parameter int unsigned        FILTER_CNT  = 4,
    parameter logic [CH_NUM-1:0]  RESET_VAL   = '0
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [CH_NUM-1:0] async_i,
    output logic [CH_NUM-1:0] data_o,
    output logic [CH_NUM-1:0] rise_o,
    output logic [CH_NUM-1:0] fall_o,
    output logic              change_o
);

    localparam int unsigned     CntW   = (FILTER_CNT > 1) ? $clog2(FILTER_CNT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CNT - 1);

    logic [CH_NUM-1:0]                    stage0_q;
    logic [SYNC_STAGES-2:0][CH_NUM-1:0]   chain_q;
    logic [CH_NUM-1:0]                    sync;
    logic [CH_NUM-1:0]                    data_q, data_d;
    logic [CH_NUM-1:0][CntW-1:0]          cnt_q, cnt_d;

    // First synchronizer stage, on the configured clock edge
    if (FIRST_EDGE != 0) begin : g_first_pos
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) stage0_q <= RESET_VAL;
            else         stage0_q <= async_i;
        end
    end else begin : g_first_neg
        always_ff @(negedge clk_i or negedge rstn_i) begin
            if (!rstn_i) stage0_q <= RESET_VAL;
            else         stage0_q <= async_i;
        end
    end

    // Remaining synchronizer stages shift on posedge
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            chain_q <= {(SYNC_STAGES-1){RESET_VAL}};
        end else begin
            chain_q[0] <= stage0_q;
            for (int i = 1; i < SYNC_STAGES - 1; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign sync = chain_q[SYNC_STAGES-2];

    // Per-channel qualification: any return to the current level restarts the count
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        for (int c = 0; c < CH_NUM; c++) begin
            if (sync[c] == data_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] == CntMax) begin
                data_d[c] = sync[c];
                cnt_d[c]  = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end
        end
    end

    // Filter state registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_q <= RESET_VAL;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o = data_q;

`ifdef MULTI_SYNC_FILTER_EDGE_EN
    logic [CH_NUM-1:0] rise_q, fall_q;

    // Strobes register on the same edge that data_q takes its new value
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= data_d & ~data_q;
            fall_q <= ~data_d & data_q;
        end
    end

    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign change_o = |(rise_q | fall_q);
`else
    assign rise_o   = '0;
    assign fall_o   = '0;
    assign change_o = 1'b0;
`endif

endmodule

// File: tb/tb_multi_sync_filter.sv
// Directed bench for multi_sync_filter at default parameters (2 stages, posedge
// first capture, FILTER_CNT = 4). Pulse expectations follow MULTI_SYNC_FILTER_EDGE_EN.

module tb_multi_sync_filter;

`ifdef MULTI_SYNC_FILTER_EDGE_EN
    localparam bit EdgeEn = 1'b1;
`else
    localparam bit EdgeEn = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic [7:0] async_in;
    logic [7:0] data;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       change;

    int n_tests = 0;
    int n_fail  = 0;

    multi_sync_filter dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .async_i  (async_in),
        .data_o   (data),
        .rise_o   (rise),
        .fall_o   (fall),
        .change_o (change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next posedge; outputs are then sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle all channels on a level, long enough for any qualification to finish
    task automatic settle(input logic [7:0] v);
        async_in = v;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        logic [7:0] exp_d, exp_r;
        logic       exp_c;
        rstn     = 1'b0;
        async_in = 8'hFF;
        repeat (3) tick();
        n_tests++;
        if (data !== 8'h00 || rise !== 8'h00 || fall !== 8'h00 || change !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: data=%h rise=%h fall=%h change=%b required 00/00/00/0",
                     data, rise, fall, change);
        end
        rstn = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            exp_d = (j >= 6) ? 8'hFF : 8'h00;
            exp_r = (EdgeEn && j == 6) ? 8'hFF : 8'h00;
            exp_c = EdgeEn && j == 6;
            n_tests++;
            if (data !== exp_d || rise !== exp_r || fall !== 8'h00 || change !== exp_c) begin
                n_fail++;
                $display("FAIL reset_release t%0d: data=%h rise=%h fall=%h change=%b required %h/%h/00/%b",
                         j, data, rise, fall, change, exp_d, exp_r, exp_c);
            end
        end
    endtask

    task automatic test_glitch();
        settle(8'h00);
        async_in = 8'h01;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 3) async_in = 8'h00;
            n_tests++;
            if (data !== 8'h00 || rise !== 8'h00 || fall !== 8'h00 || change !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch t%0d: data=%h rise=%h fall=%h change=%b required 00/00/00/0",
                         j, data, rise, fall, change);
            end
        end
    endtask

    task automatic test_pulse();
        logic [7:0] exp_d, exp_r, exp_f;
        logic       exp_c;
        settle(8'h00);
        async_in = 8'h01;
        for (int j = 1; j <= 13; j++) begin
            tick();
            if (j == 4) async_in = 8'h00;
            exp_d = (j >= 6 && j <= 9) ? 8'h01 : 8'h00;
            exp_r = (EdgeEn && j == 6)  ? 8'h01 : 8'h00;
            exp_f = (EdgeEn && j == 10) ? 8'h01 : 8'h00;
            exp_c = EdgeEn && (j == 6 || j == 10);
            n_tests++;
            if (data !== exp_d || rise !== exp_r || fall !== exp_f || change !== exp_c) begin
                n_fail++;
                $display("FAIL pulse t%0d: data=%h rise=%h fall=%h change=%b required %h/%h/%h/%b",
                         j, data, rise, fall, change, exp_d, exp_r, exp_f, exp_c);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_d, exp_r, exp_f;
        logic       exp_c;
        int         n_change = 0;
        settle(8'h04);
        async_in = 8'h02;
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (change === 1'b1) n_change++;
            exp_d = (j >= 6) ? 8'h02 : 8'h04;
            exp_r = (EdgeEn && j == 6) ? 8'h02 : 8'h00;
            exp_f = (EdgeEn && j == 6) ? 8'h04 : 8'h00;
            exp_c = EdgeEn && j == 6;
            n_tests++;
            if (data !== exp_d || rise !== exp_r || fall !== exp_f || change !== exp_c) begin
                n_fail++;
                $display("FAIL simultaneous t%0d: data=%h rise=%h fall=%h change=%b required %h/%h/%h/%b",
                         j, data, rise, fall, change, exp_d, exp_r, exp_f, exp_c);
            end
        end
        n_tests++;
        if (n_change !== (EdgeEn ? 1 : 0)) begin
            n_fail++;
            $display("FAIL simultaneous_count: change cycles=%0d required %0d",
                     n_change, EdgeEn ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_d, exp_r;
        logic       exp_c;
        settle(8'h01);
        n_tests++;
        if (data !== 8'h01) begin
            n_fail++;
            $display("FAIL mid_setup: data=%h required 01", data);
        end
        // s[3] changes after the 2nd tick; reset lands 2 cycles later, mid-count
        async_in = 8'h09;
        repeat (4) tick();
        #2;
        rstn = 1'b0;
        #1;
        n_tests++;
        if (data !== 8'h00 || rise !== 8'h00 || fall !== 8'h00 || change !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_assert: data=%h rise=%h fall=%h change=%b required 00/00/00/0",
                     data, rise, fall, change);
        end
        repeat (2) tick();
        rstn = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            exp_d = (j >= 6) ? 8'h09 : 8'h00;
            exp_r = (EdgeEn && j == 6) ? 8'h09 : 8'h00;
            exp_c = EdgeEn && j == 6;
            n_tests++;
            if (data !== exp_d || rise !== exp_r || fall !== 8'h00 || change !== exp_c) begin
                n_fail++;
                $display("FAIL mid_release t%0d: data=%h rise=%h fall=%h change=%b required %h/%h/00/%b",
                         j, data, rise, fall, change, exp_d, exp_r, exp_c);
            end
        end
    endtask

    initial begin
        rstn     = 1'b0;
        async_in = 8'h00;
        test_reset();
        test_glitch();
        test_pulse();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
